ysyx_23060072_mem_arbiter: RTL and testbench

- Shares one data-memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Sits between those two requesters and the single memory slave.
- Grants one transaction at a time: round-robin arbitration, latched request, wait for the slave response, route the response back to the owner.
- The LSU-stage hold logic depends on its `lsu_req_ready` and `lsu_rsp_valid` outputs.

---
 rtl/ysyx_23060072_mem_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_ysyx_23060072_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060072_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_23060072_mem_arbiter
//
// Shares one data-memory slave port between the instruction-fetch unit (IFU)
// and the load/store unit (LSU). One transaction is in flight at a time:
// round-robin grant in IDLE, the winning request is latched and presented to
// the slave in ISSUE, and WAIT holds until the slave responds. The response
// is then registered and routed back to the owner as a one-cycle strobe.
//
// Ports
//   clk, rst                 clock (posedge) and synchronous active-high reset
//   ifu_req_valid/ifu_addr   IFU read request; ifu_req_ready = accepted
//   ifu_rsp_valid/_data      IFU read response strobe and held data
//   lsu_req_valid/lsu_wen/lsu_addr/lsu_wdata/lsu_wmask
//                            LSU load/store request; lsu_req_ready = accepted
//   lsu_rsp_valid/_data      LSU response strobe; data is 0 for stores
//   mem_req_*/mem_wen/mem_addr/mem_wdata/mem_wmask
//                            request channel to the memory slave
//   mem_rsp_valid/_data      response channel from the memory slave
//   rsp_err                  response produced by timeout
//   busy                     arbiter is not IDLE
//
// Optional build macro
//   YSYX_23060072_MEM_ARB_TIMEOUT_EN : when defined, a WAIT lasting TIMEOUT
//   cycles without a slave response completes with 32'hDEAD_BEEF and
//   rsp_err=1. When undefined, WAIT waits indefinitely and rsp_err is 0.
// ----------------------------------------------------------------------------
module ysyx_23060072_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   // IFU
   input  logic                ifu_req_valid,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_req_ready,
   output logic                ifu_rsp_valid,
   output logic [DATA_W-1:0]   ifu_rsp_data,
   // LSU
   input  logic                lsu_req_valid,
   input  logic                lsu_wen,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_req_ready,
   output logic                lsu_rsp_valid,
   output logic [DATA_W-1:0]   lsu_rsp_data,
   // memory slave
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_wen,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rsp_data,
   // status
   output logic                rsp_err,
   output logic                busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   state_e              state_q, state_d;

   // Owner / last_grant encoding: 0 = IFU, 1 = LSU.
   logic                last_grant_q;
   logic                owner_q;

   // Latched request
   logic                wen_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wmask_q;

   // Registered responses
   logic                ifu_rsp_valid_q;
   logic [DATA_W-1:0]   ifu_rsp_data_q;
   logic                lsu_rsp_valid_q;
   logic [DATA_W-1:0]   lsu_rsp_data_q;

   logic                is_idle;
   logic                ifu_grant;
   logic                lsu_grant;
   logic                handshake;
   logic                rsp_done;
   logic                timeout_hit;

   assign is_idle = (state_q == ST_IDLE);

   // On a conflict the requester that did not win last time is preferred;
   // last_grant resets to IFU so the LSU wins the first conflict.
   assign ifu_grant = is_idle && ifu_req_valid && (!lsu_req_valid ||  last_grant_q);
   assign lsu_grant = is_idle && lsu_req_valid && (!ifu_req_valid || !last_grant_q);
   assign handshake = ifu_grant || lsu_grant;

   // Slave responses outside WAIT are ignored.
   assign rsp_done  = (state_q == ST_WAIT) && mem_rsp_valid;

`ifdef YSYX_23060072_MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [CNT_W-1:0] cnt_q;
   logic             rsp_err_q;

   // Counter is 0 in the first WAIT cycle; firing at TIMEOUT-1 makes the
   // timeout response visible TIMEOUT cycles after entering WAIT.
   assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         if (state_q == ST_ISSUE && mem_req_ready) begin
            cnt_q <= '0;
         end else if (state_q == ST_WAIT) begin
            cnt_q <= cnt_q + 1'b1;
         end
         // A real response arriving with the timeout takes precedence.
         rsp_err_q <= timeout_hit && !rsp_done;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   logic unused_cfg;
   assign unused_cfg  = (TIMEOUT == 0);
   assign timeout_hit = 1'b0;
   assign rsp_err     = 1'b0;
`endif

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------- next-state comb
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (handshake)                  state_d = ST_ISSUE;
         ST_ISSUE: if (mem_req_ready)              state_d = ST_WAIT;
         ST_WAIT:  if (rsp_done || timeout_hit)    state_d = ST_IDLE;
         default:                                  state_d = ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------- output comb
   always_comb begin
      ifu_req_ready = ifu_grant;
      lsu_req_ready = lsu_grant;
      mem_req_valid = (state_q == ST_ISSUE);
      busy          = !is_idle;
   end

   assign mem_wen       = wen_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;
   assign ifu_rsp_valid = ifu_rsp_valid_q;
   assign ifu_rsp_data  = ifu_rsp_data_q;
   assign lsu_rsp_valid = lsu_rsp_valid_q;
   assign lsu_rsp_data  = lsu_rsp_data_q;

   // ------------------------------------------------ request latch / response
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q    <= 1'b0;
         owner_q         <= 1'b0;
         wen_q           <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         wmask_q         <= '0;
         ifu_rsp_valid_q <= 1'b0;
         ifu_rsp_data_q  <= '0;
         lsu_rsp_valid_q <= 1'b0;
         lsu_rsp_data_q  <= '0;
      end else begin
         if (handshake) begin
            owner_q      <= lsu_grant;
            last_grant_q <= lsu_grant;
            if (lsu_grant) begin
               wen_q   <= lsu_wen;
               addr_q  <= lsu_addr;
               wdata_q <= lsu_wdata;
               wmask_q <= lsu_wmask;
            end else begin
               wen_q   <= 1'b0;
               addr_q  <= ifu_addr;
               wdata_q <= '0;
               wmask_q <= '0;
            end
         end

         // Strobes are single-cycle; data registers hold until overwritten.
         ifu_rsp_valid_q <= 1'b0;
         lsu_rsp_valid_q <= 1'b0;

         if (rsp_done) begin
            if (owner_q) begin
               lsu_rsp_valid_q <= 1'b1;
               lsu_rsp_data_q  <= wen_q ? '0 : mem_rsp_data;
            end else begin
               ifu_rsp_valid_q <= 1'b1;
               ifu_rsp_data_q  <= mem_rsp_data;
            end
         end else if (timeout_hit) begin
            if (owner_q) begin
               lsu_rsp_valid_q <= 1'b1;
               lsu_rsp_data_q  <= DATA_W'(32'hDEAD_BEEF);
            end else begin
               ifu_rsp_valid_q <= 1'b1;
               ifu_rsp_data_q  <= DATA_W'(32'hDEAD_BEEF);
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060072_mem_arbiter.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for ysyx_23060072_mem_arbiter. Expected
// responses are queued when a grant is predicted and popped when a response
// strobe appears. Outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_ysyx_23060072_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid;
   logic [31:0] ifu_addr;
   logic        ifu_req_ready;
   logic        ifu_rsp_valid;
   logic [31:0] ifu_rsp_data;
   logic        lsu_req_valid;
   logic        lsu_wen;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        lsu_req_ready;
   logic        lsu_rsp_valid;
   logic [31:0] lsu_rsp_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        rsp_err;
   logic        busy;

   always #5 clk = ~clk;

   ysyx_23060072_mem_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ifu_req_valid(ifu_req_valid),
      .ifu_addr     (ifu_addr),
      .ifu_req_ready(ifu_req_ready),
      .ifu_rsp_valid(ifu_rsp_valid),
      .ifu_rsp_data (ifu_rsp_data),
      .lsu_req_valid(lsu_req_valid),
      .lsu_wen      (lsu_wen),
      .lsu_addr     (lsu_addr),
      .lsu_wdata    (lsu_wdata),
      .lsu_wmask    (lsu_wmask),
      .lsu_req_ready(lsu_req_ready),
      .lsu_rsp_valid(lsu_rsp_valid),
      .lsu_rsp_data (lsu_rsp_data),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_wen      (mem_wen),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wmask    (mem_wmask),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data (mem_rsp_data),
      .rsp_err      (rsp_err),
      .busy         (busy)
   );

   typedef struct packed {
      logic        owner;   // 1 = LSU
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Checks the response strobe against the head of the scoreboard.
   task automatic check_rsp(input string tag);
      exp_t e;
      logic got_lsu;
      check({tag, "_one_strobe"}, ifu_rsp_valid ^ lsu_rsp_valid, 1);
      check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         got_lsu = lsu_rsp_valid;
         check({tag, "_owner"}, got_lsu, e.owner);
         check({tag, "_data"}, e.owner ? lsu_rsp_data : ifu_rsp_data, e.data);
         check({tag, "_err"}, rsp_err, e.err);
      end
   endtask

   // Serves one transaction: caller has driven the request inputs in IDLE.
   task automatic serve(input string tag, input bit exp_lsu, input int stall,
                        input logic [31:0] sdata);
      logic [31:0] e_addr, e_wdata;
      logic        e_wen;
      logic [3:0]  e_wmask;
      exp_t        e;
      #1;
      check({tag, "_ifu_ready"}, ifu_req_ready, !exp_lsu);
      check({tag, "_lsu_ready"}, lsu_req_ready, exp_lsu);
      if (exp_lsu) begin
         e_addr = lsu_addr; e_wen = lsu_wen; e_wdata = lsu_wdata; e_wmask = lsu_wmask;
      end else begin
         e_addr = ifu_addr; e_wen = 1'b0; e_wdata = '0; e_wmask = '0;
      end
      e.owner = exp_lsu;
      e.data  = (exp_lsu && lsu_wen) ? 32'h0 : sdata;
      e.err   = 1'b0;
      sb.push_back(e);

      tick;   // handshake edge -> ISSUE
      if (exp_lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
      #1;
      check({tag, "_strobes_clear"}, {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
      check({tag, "_no_ready_in_issue"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
      check({tag, "_mem_req_valid"}, mem_req_valid, 1);
      check({tag, "_mem_fields"}, {mem_wen, mem_addr, mem_wmask}, {e_wen, e_addr, e_wmask});
      check({tag, "_mem_wdata"}, mem_wdata, e_wdata);

      for (int i = 0; i < stall; i++) begin
         tick;
         check({tag, "_stall_valid"}, mem_req_valid, 1);
         check({tag, "_stall_stable"}, {mem_wen, mem_addr, mem_wdata, mem_wmask},
               {e_wen, e_addr, e_wdata, e_wmask});
      end

      mem_req_ready = 1'b1;
      tick;   // -> WAIT
      mem_req_ready = 1'b0;
      check({tag, "_wait_no_req"}, mem_req_valid, 0);
      check({tag, "_wait_busy"}, busy, 1);

      mem_rsp_valid = 1'b1;
      mem_rsp_data  = sdata;
      tick;   // -> IDLE, response registered
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
      check_rsp(tag);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      rst           = 1'b1;
      ifu_req_valid = 1'b0; ifu_addr  = '0;
      lsu_req_valid = 1'b0; lsu_wen   = 1'b0; lsu_addr = '0;
      lsu_wdata     = '0;   lsu_wmask = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
      repeat (2) tick;
      rst = 1'b0;
      tick;

      // Reset state: all outputs 0.
      check("rst_ready", {ifu_req_ready, lsu_req_ready}, 0);
      check("rst_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 0);
      check("rst_rsp_data", {ifu_rsp_data, lsu_rsp_data}, 0);
      check("rst_mem", {mem_req_valid, mem_wen, mem_addr, mem_wmask}, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_err_busy", {rsp_err, busy}, 0);

      // Slave response in IDLE is ignored.
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1111_2222;
      tick;
      mem_rsp_valid = 1'b0;
      check("idle_rsp_ignored_a", {ifu_rsp_valid, lsu_rsp_valid, busy}, 0);
      tick;
      check("idle_rsp_ignored_b", {ifu_rsp_valid, lsu_rsp_valid, busy}, 0);

      // Arbitration: both valid from reset -> LSU, then IFU, then LSU.
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
      lsu_req_valid = 1'b1; lsu_wen  = 1'b0; lsu_addr = 32'h8000_2000;
      lsu_wdata = 32'h0; lsu_wmask = 4'h0;
      serve("arb1", 1'b1, 0, 32'hAAAA_0001);
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2004;
      serve("arb2", 1'b0, 0, 32'hAAAA_0002);
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0014;
      serve("arb3", 1'b1, 0, 32'hAAAA_0003);
      serve("arb4", 1'b0, 0, 32'hAAAA_0004);   // IFU still pending

      // IFU-only read, zero-wait slave.
      tick;
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
      serve("ifu_rd", 1'b0, 0, 32'h0000_0413);
      check("ifu_rd_hold", ifu_rsp_data, 32'h0000_0413);

      // LSU store with 3-cycle request stall.
      lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1004;
      lsu_wdata = 32'hA5A5_A5A5; lsu_wmask = 4'b0011;
      serve("lsu_st", 1'b1, 3, 32'h1234_5678);
      tick;
      check("ifu_data_held", ifu_rsp_data, 32'h0000_0413);

      // Reset while in WAIT abandons the transaction.
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
      tick;
      ifu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick;
      mem_req_ready = 1'b0;
      check("rstw_in_wait", {busy, mem_req_valid}, 2'b10);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("rstw_idle", busy, 0);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_6666;
      tick;
      mem_rsp_valid = 1'b0;
      check("rstw_no_strobe", {ifu_rsp_valid, lsu_rsp_valid, busy}, 0);
      tick;
      check("rstw_no_strobe_b", {ifu_rsp_valid, lsu_rsp_valid}, 0);
      lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_3000;
      lsu_wdata = 32'h0; lsu_wmask = 4'h0;
      serve("rstw_after", 1'b1, 1, 32'hCAFE_F00D);

`ifdef YSYX_23060072_MEM_ARB_TIMEOUT_EN
      begin
         exp_t e;
         int   cycles;
         tick;
         lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_4000;
         e.owner = 1'b1; e.data = 32'hDEAD_BEEF; e.err = 1'b1;
         sb.push_back(e);
         tick;
         lsu_req_valid = 1'b0;
         mem_req_ready = 1'b1;
         tick;   // now in WAIT
         mem_req_ready = 1'b0;
         cycles = 0;
         while (!lsu_rsp_valid && !ifu_rsp_valid && cycles < 20) begin
            tick;
            cycles++;
         end
         check("to_latency", cycles, 4);
         check_rsp("to");
         check("to_idle", busy, 0);
         tick;
         check("to_err_pulse", {rsp_err, lsu_rsp_valid}, 0);
      end
`endif

      check("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
